vdp_host_sequencer: RTL and testbench
=====================================

Name: vdp_host_sequencer

Overview:
- Initiator for the TMS9918A/F18A CPU-side port: drives `mode`, `csw_n`, `csr_n` and `cd` with the timing the VDP expects.
- Takes a simple command stream: register write, VRAM address set, VRAM data write/read, status read.
- Sits between on-board masters (boot loader, GPU-assisted init, test harness) and the f18a host port; muxed with the Apple II bus path at the top level.

Parameters:
- SETUP_CYCLES, 1, clocks `mode`/`cd` are stable before the strobe asserts (>=1)
- STROBE_CYCLES, 4, clocks `csw_n`/`csr_n` are held low (>=1)
- RECOVERY_CYCLES, 8, idle clocks after each strobe before the next byte or IDLE (>=1)

Ports:
- `clk_logic_i` in 1: logic clock
- `reset_i` in 1: synchronous active-high reset
- `cmd_valid_i` in 1: command offered
- `cmd_ready_o` out 1: high only in IDLE; accept = valid&ready
- `cmd_op_i` in 3: 0 REG_WRITE, 1 SET_WRITE_ADDR, 2 SET_READ_ADDR, 3 VRAM_WRITE, 4 VRAM_READ, 5 STATUS_READ, 6-7 invalid
- `cmd_addr_i` in 14: VRAM address (ops 1,2); register number in [5:0] (op 0)
- `cmd_data_i` in 8: write data (ops 0,3)
- `rsp_valid_o` out 1: one-cycle pulse with read data
- `rsp_data_o` out 8: captured read byte; holds until next read
- `cmd_err_o` out 1: one-cycle pulse on invalid op
- `busy_o` out 1: ~`cmd_ready_o`
- `vdp_mode_o` out 1: VDP MODE pin
- `vdp_csw_n_o` out 1: write strobe, active low
- `vdp_csr_n_o` out 1: read strobe, active low
- `vdp_cd_o` out 8: write data to the VDP
- `vdp_cd_i` in 8: read data from the VDP
- `vram_addr_o` out 14: shadow VRAM pointer (optional feature only)

Behaviour:
- Reset (`reset_i` high at an edge):
  - state IDLE; `csw_n`/`csr_n` = 1; `mode` = 0; `cd_o` = 0.
  - `rsp_valid`, `cmd_err` = 0; `rsp_data` = 0.
  - A command presented in a reset cycle is discarded; reset wins over everything.
- States: IDLE -> SETUP -> STROBE -> RECOVER -> (SETUP for the second byte | IDLE).
- Byte sequences (`mode`, byte):
  - op0: (1, data), then (1, 0x80 | reg[5:0])
  - op1: (1, addr[7:0]), then (1, 0x40 | addr[13:8])
  - op2: (1, addr[7:0]), then (1, {2'b00, addr[13:8]})
  - op3: (0, data), written
  - op4: (0) read
  - op5: (1) read
- Command fields are registered at accept; input changes after accept have no effect.
- Timing per byte, with acceptance at edge T:
  - SETUP occupies cycles T+1 .. T+SETUP_CYCLES; `mode`/`cd` are valid from T+1.
  - Strobe is low for exactly STROBE_CYCLES, then RECOVER for RECOVERY_CYCLES.
  - `mode`/`cd_o` hold through STROBE and return to 0 in RECOVER.
- Busy time: one byte = SETUP+STROBE+RECOVERY = 13 cycles at default; two bytes = 26. `cmd_ready_o` rises the cycle after the last RECOVER cycle.
- Reads:
  - `vdp_cd_i` is sampled on the last STROBE cycle.
  - `rsp_valid_o` pulses in the first RECOVER cycle, with `rsp_data_o` valid in that same cycle.
- Never both strobes low at once. Strobes are registered outputs, so no glitches.
- Invalid op (6, 7):
  - Accepted; `cmd_err_o` pulses the cycle after accept.
  - No bus activity; remains IDLE with ready = 1.
- Counters are sized `$clog2(max param + 1)` and saturate on reload, with no wrap mid-phase.
- Reset mid-operation: strobes high the next cycle, no `rsp_valid`, no `cmd_err`, the command is lost; `vram_addr` resets to 0.

Optional Feature:
- Macro: VDP_SEQ_ADDR_TRACK_EN.
- When defined, `vram_addr_o` mirrors the VDP internal address pointer:
  - loaded with `cmd_addr_i` at completion of op1/op2;
  - incremented modulo 0x4000 after each op3/op4 strobe;
  - op0/op5 leave it unchanged;
  - reset value 0.
- When undefined: the port exists, is tied to 0, and adds no logic.

Test Plan:
- REG_WRITE reg=7 data=0xF4 -> `mode` = 1:
  - bytes 0xF4 then 0x87;
  - `csw_n` low 4 cycles each, gap 8;
  - `cmd_ready_o` low exactly 26 cycles;
  - `csr_n` stays high.
- SET_WRITE_ADDR 0x3800, then VRAM_WRITE 0xAA -> bytes 0x00, 0x78 at `mode` = 1, then 0xAA at `mode` = 0; setup >= 1 cycle before each `csw_n` fall.
- VRAM_READ with `vdp_cd_i` = 0x5A -> `csr_n` low 4 cycles at `mode` = 0; single `rsp_valid_o` pulse with `rsp_data_o` = 0x5A; STATUS_READ with 0x80 -> same at `mode` = 1, data 0x80.
- op=7 -> `cmd_err_o` one-cycle pulse; no strobe activity; `cmd_ready_o` remains 1; back-to-back valid commands are each accepted only in IDLE.
- `reset_i` asserted during the second-byte STROBE of REG_WRITE -> `csw_n` = 1 next cycle; ready = 1; no pulses; a subsequent command executes normally.
- With VDP_SEQ_ADDR_TRACK_EN: SET_WRITE_ADDR 0x3FFE, then 3× VRAM_WRITE -> `vram_addr_o` 0x3FFE, 0x3FFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/vdp_host_sequencer.sv
// Command-driven initiator for the TMS9918A/F18A CPU port (mode/csw_n/csr_n/cd).
// Optional VRAM pointer shadow: define VDP_SEQ_ADDR_TRACK_EN.
module vdp_host_sequencer #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 8
) (
    input  logic        clk_logic_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [13:0] cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        cmd_err_o,
    output logic        busy_o,
    output logic        vdp_mode_o,
    output logic        vdp_csw_n_o,
    output logic        vdp_csr_n_o,
    output logic [7:0]  vdp_cd_o,
    input  logic [7:0]  vdp_cd_i,
    output logic [13:0] vram_addr_o
);

    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_P = (MAX_A > RECOVERY_CYCLES) ? MAX_A : RECOVERY_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LD  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] RECOVER_LD = CW'(RECOVERY_CYCLES - 1);

    localparam logic [2:0] OP_REG   = 3'd0;
    localparam logic [2:0] OP_WADDR = 3'd1;
    localparam logic [2:0] OP_RADDR = 3'd2;
    localparam logic [2:0] OP_VWR   = 3'd3;
    localparam logic [2:0] OP_VRD   = 3'd4;
    localparam logic [2:0] OP_STAT  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          second_q;
    logic          second_n;
    logic          last;

    logic [2:0]    op_q;
    logic [13:0]   addr_q;
    logic [7:0]    data_q;

    logic          accept;
    logic          op_ok;
    logic          two_byte;

    logic [2:0]    sel_op;
    logic [13:0]   sel_addr;
    logic [7:0]    sel_data;

    logic          mode_q;
    logic          mode_d;
    logic [7:0]    cd_q;
    logic [7:0]    cd_d;
    logic          csw_q;
    logic          csw_d;
    logic          csr_q;
    logic          csr_d;
    logic          rsp_valid_q;
    logic          rsp_valid_d;
    logic [7:0]    rsp_data_q;
    logic          err_q;
    logic          err_d;

    function automatic logic is_read(input logic [2:0] op);
        return (op == OP_VRD) || (op == OP_STAT);
    endfunction

    function automatic logic mode_of(input logic [2:0] op);
        return !((op == OP_VWR) || (op == OP_VRD));
    endfunction

    function automatic logic [7:0] byte_of(
        input logic [2:0]  op,
        input logic [13:0] addr,
        input logic [7:0]  data,
        input logic        hi
    );
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_REG:   b = hi ? {2'b10, addr[5:0]} : data;
            OP_WADDR: b = hi ? {2'b01, addr[13:8]} : addr[7:0];
            OP_RADDR: b = hi ? {2'b00, addr[13:8]} : addr[7:0];
            OP_VWR:   b = data;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign op_ok       = (cmd_op_i <= OP_STAT);
    assign two_byte    = (op_q == OP_REG) || (op_q == OP_WADDR) || (op_q == OP_RADDR);
    assign last        = (cnt == '0);

    // While idle the bus values come straight from the command being accepted.
    assign sel_op   = (state == IDLE) ? cmd_op_i   : op_q;
    assign sel_addr = (state == IDLE) ? cmd_addr_i : addr_q;
    assign sel_data = (state == IDLE) ? cmd_data_i : data_q;

    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= '0;
            second_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            second_q <= second_n;
        end
    end

    always_comb begin
        state_n  = state;
        second_n = second_q;
        cnt_n    = last ? cnt : cnt - 1'b1;
        case (state)
            IDLE: begin
                if (accept && op_ok) begin
                    state_n  = SETUP;
                    cnt_n    = SETUP_LD;
                    second_n = 1'b0;
                end
            end
            SETUP: begin
                if (last) begin
                    state_n = STROBE;
                    cnt_n   = STROBE_LD;
                end
            end
            STROBE: begin
                if (last) begin
                    state_n = RECOVER;
                    cnt_n   = RECOVER_LD;
                end
            end
            RECOVER: begin
                if (last) begin
                    if (two_byte && !second_q) begin
                        state_n  = SETUP;
                        cnt_n    = SETUP_LD;
                        second_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered bus pins, so strobes never glitch.
    always_comb begin
        mode_d = 1'b0;
        cd_d   = 8'h00;
        csw_d  = 1'b1;
        csr_d  = 1'b1;
        if (state_n == SETUP || state_n == STROBE) begin
            mode_d = mode_of(sel_op);
            cd_d   = byte_of(sel_op, sel_addr, sel_data, second_n);
        end
        if (state_n == STROBE) begin
            if (is_read(sel_op)) begin
                csr_d = 1'b0;
            end else begin
                csw_d = 1'b0;
            end
        end
        rsp_valid_d = (state == STROBE) && last && is_read(op_q);
        err_d       = accept && !op_ok;
    end

    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            cd_q        <= 8'h00;
            csw_q       <= 1'b1;
            csr_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            if (accept && op_ok) begin
                op_q   <= cmd_op_i;
                addr_q <= cmd_addr_i;
                data_q <= cmd_data_i;
            end
            mode_q      <= mode_d;
            cd_q        <= cd_d;
            csw_q       <= csw_d;
            csr_q       <= csr_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            if (rsp_valid_d) begin
                rsp_data_q <= vdp_cd_i;
            end
        end
    end

    assign vdp_mode_o  = mode_q;
    assign vdp_cd_o    = cd_q;
    assign vdp_csw_n_o = csw_q;
    assign vdp_csr_n_o = csr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign cmd_err_o   = err_q;

`ifdef VDP_SEQ_ADDR_TRACK_EN
    logic [13:0] vram_q;

    // Mirrors the VDP's auto-incrementing pointer.
    always_ff @(posedge clk_logic_i) begin
        if (reset_i) begin
            vram_q <= '0;
        end else if (state == STROBE && last &&
                     (op_q == OP_VWR || op_q == OP_VRD)) begin
            vram_q <= vram_q + 14'd1;
        end else if (state == RECOVER && last && second_q &&
                     (op_q == OP_WADDR || op_q == OP_RADDR)) begin
            vram_q <= addr_q;
        end
    end

    assign vram_addr_o = vram_q;
`else
    assign vram_addr_o = '0;
`endif

endmodule

// File: tb/tb_vdp_host_sequencer.sv
// Directed self-checking bench for vdp_host_sequencer.
// Bus activity is logged by a passive negedge monitor; each test checks inline.
module tb_vdp_host_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [13:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        cmd_err;
    logic        busy;
    logic        vdp_mode;
    logic        vdp_csw_n;
    logic        vdp_csr_n;
    logic [7:0]  vdp_cd_out;
    logic [7:0]  vdp_cd_in;
    logic [13:0] vram_addr;
    logic [7:0]  rd_val = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The VDP only drives valid data while csr_n is low.
    assign vdp_cd_in = vdp_csr_n ? 8'hFF : rd_val;

    vdp_host_sequencer dut (
        .clk_logic_i (clk),
        .reset_i     (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .cmd_err_o   (cmd_err),
        .busy_o      (busy),
        .vdp_mode_o  (vdp_mode),
        .vdp_csw_n_o (vdp_csw_n),
        .vdp_csr_n_o (vdp_csr_n),
        .vdp_cd_o    (vdp_cd_out),
        .vdp_cd_i    (vdp_cd_in),
        .vram_addr_o (vram_addr)
    );

    logic [8:0] wq[$];
    int         wfall[$];
    int         wrise[$];
    int         wlen[$];
    logic       rq[$];
    int         rfall[$];
    int         rlen[$];
    int         ncyc = 0;
    int         busy_cyc = 0;
    int         rsp_n = 0;
    logic [7:0] rsp_last = 8'h00;
    int         err_n = 0;
    int         setup_bad = 0;
    int         both_low = 0;
    int         accepts = 0;
    logic       prev_csw = 1'b1;
    logic       prev_csr = 1'b1;
    logic       prev_mode = 1'b0;
    logic [7:0] prev_cd = 8'h00;

    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) accepts++;
    end

    always @(negedge clk) begin
        if (!vdp_csw_n && !vdp_csr_n) both_low++;
        if (!cmd_ready) busy_cyc++;
        if (rsp_valid) begin
            rsp_n++;
            rsp_last = rsp_data;
        end
        if (cmd_err) err_n++;
        if (!vdp_csw_n && prev_csw) begin
            wq.push_back({vdp_mode, vdp_cd_out});
            wfall.push_back(ncyc);
            if (prev_mode !== vdp_mode || prev_cd !== vdp_cd_out) setup_bad++;
        end
        if (vdp_csw_n && !prev_csw && wfall.size() > 0) begin
            wlen.push_back(ncyc - wfall[wfall.size()-1]);
            wrise.push_back(ncyc);
        end
        if (!vdp_csr_n && prev_csr) begin
            rq.push_back(vdp_mode);
            rfall.push_back(ncyc);
            if (prev_mode !== vdp_mode) setup_bad++;
        end
        if (vdp_csr_n && !prev_csr && rfall.size() > 0) begin
            rlen.push_back(ncyc - rfall[rfall.size()-1]);
        end
        prev_csw  = vdp_csw_n;
        prev_csr  = vdp_csr_n;
        prev_mode = vdp_mode;
        prev_cd   = vdp_cd_out;
        ncyc++;
    end

    task automatic clear_log();
        wq.delete(); wfall.delete(); wrise.delete(); wlen.delete();
        rq.delete(); rfall.delete(); rlen.delete();
        busy_cyc = 0; rsp_n = 0; err_n = 0; setup_bad = 0; accepts = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [13:0] a, input logic [7:0] d);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL issue_timeout: ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_addr = a;
        cmd_data = d;
        step(1);
        cmd_valid = 1'b0;
        cmd_op = 3'd6;
        cmd_addr = ~a;
        cmd_data = ~d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout: ready=%0b required 1", cmd_ready);
        end
        step(2);
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1;
        cmd_op = 3'd0;
        cmd_data = 8'h12;
        step(3);
        @(negedge clk);
        checks++;
        if ({vdp_csw_n, vdp_csr_n, vdp_mode} !== 3'b110) begin
            errors++;
            $display("FAIL reset_pins: csw/csr/mode=%b required 110", {vdp_csw_n, vdp_csr_n, vdp_mode});
        end
        checks++;
        if (vdp_cd_out !== 8'h00 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: cd=%h rsp=%h required 00 00", vdp_cd_out, rsp_data);
        end
        checks++;
        if ({rsp_valid, cmd_err, cmd_ready, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_flags: v/e/r/b=%b required 0010", {rsp_valid, cmd_err, cmd_ready, busy});
        end
        checks++;
        if (vram_addr !== 14'h0) begin
            errors++;
            $display("FAIL reset_vram: %h required 0000", vram_addr);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        clear_log();
        step(20);
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: writes=%0d reads=%0d ready=%b required 0 0 1",
                     wq.size(), rq.size(), cmd_ready);
        end
    endtask

    task automatic test_reg_write();
        clear_log();
        issue(3'd0, 14'd7, 8'hF4);
        wait_idle();
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL regw_count: %0d bytes required 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 9'h1F4 || wq[1] !== 9'h187) begin
                errors++;
                $display("FAIL regw_bytes: %h %h required 1f4 187", wq[0], wq[1]);
            end
        end
        checks++;
        if (wlen.size() != 2 || wlen[0] != 4 || wlen[1] != 4) begin
            errors++;
            $display("FAIL regw_strobe_len: n=%0d required two strobes of 4", wlen.size());
        end
        // High time between strobes = 8 recovery + 1 setup
        checks++;
        if (wfall.size() != 2 || wrise.size() < 1 || wfall[1] - wrise[0] != 9) begin
            errors++;
            $display("FAIL regw_gap: falls=%0d rises=%0d required gap 9", wfall.size(), wrise.size());
        end
        checks++;
        if (busy_cyc != 26) begin
            errors++;
            $display("FAIL regw_busy: %0d cycles required 26", busy_cyc);
        end
        checks++;
        if (rq.size() != 0 || setup_bad != 0) begin
            errors++;
            $display("FAIL regw_csr_setup: reads=%0d setup_bad=%0d required 0 0", rq.size(), setup_bad);
        end
    endtask

    task automatic test_addr_write();
        clear_log();
        issue(3'd1, 14'h3800, 8'h00);
        issue(3'd3, 14'h0000, 8'hAA);
        wait_idle();
        checks++;
        if (wq.size() != 3) begin
            errors++;
            $display("FAIL addrw_count: %0d bytes required 3", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 9'h100 || wq[1] !== 9'h178 || wq[2] !== 9'h0AA) begin
                errors++;
                $display("FAIL addrw_bytes: %h %h %h required 100 178 0aa", wq[0], wq[1], wq[2]);
            end
        end
        checks++;
        if (setup_bad != 0 || busy_cyc != 39) begin
            errors++;
            $display("FAIL addrw_setup_busy: setup_bad=%0d busy=%0d required 0 39", setup_bad, busy_cyc);
        end
    endtask

    task automatic test_reads();
        clear_log();
        rd_val = 8'h5A;
        issue(3'd4, 14'h0000, 8'h00);
        wait_idle();
        checks++;
        if (rq.size() != 1 || rq[0] !== 1'b0 || rlen.size() != 1 || rlen[0] != 4) begin
            errors++;
            $display("FAIL vrd_strobe: reads=%0d required one mode-0 strobe of 4", rq.size());
        end
        checks++;
        if (rsp_n != 1 || rsp_last !== 8'h5A) begin
            errors++;
            $display("FAIL vrd_rsp: pulses=%0d data=%h required 1 5a", rsp_n, rsp_last);
        end
        checks++;
        if (rsp_data !== 8'h5A || wq.size() != 0) begin
            errors++;
            $display("FAIL vrd_hold: rsp_data=%h writes=%0d required 5a 0", rsp_data, wq.size());
        end
        clear_log();
        rd_val = 8'h80;
        issue(3'd5, 14'h0000, 8'h00);
        wait_idle();
        checks++;
        if (rq.size() != 1 || rq[0] !== 1'b1 || rlen.size() != 1 || rlen[0] != 4) begin
            errors++;
            $display("FAIL stat_strobe: reads=%0d required one mode-1 strobe of 4", rq.size());
        end
        checks++;
        if (rsp_n != 1 || rsp_last !== 8'h80 || busy_cyc != 13) begin
            errors++;
            $display("FAIL stat_rsp: pulses=%0d data=%h busy=%0d required 1 80 13", rsp_n, rsp_last, busy_cyc);
        end
    endtask

    task automatic test_invalid();
        clear_log();
        issue(3'd7, 14'h1234, 8'h55);
        checks++;
        if (cmd_err !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL inv_pulse: err=%b ready=%b required 1 1", cmd_err, cmd_ready);
        end
        step(1);
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL inv_width: err=%b required 0", cmd_err);
        end
        step(15);
        checks++;
        if (err_n != 1 || wq.size() != 0 || rq.size() != 0 || busy_cyc != 0) begin
            errors++;
            $display("FAIL inv_quiet: errs=%0d writes=%0d reads=%0d busy=%0d required 1 0 0 0",
                     err_n, wq.size(), rq.size(), busy_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        cmd_valid = 1'b1;
        cmd_op = 3'd3;
        cmd_data = 8'h11;
        step(30);
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (accepts != 3 || wq.size() != 3) begin
            errors++;
            $display("FAIL b2b_accepts: accepts=%0d writes=%0d required 3 3", accepts, wq.size());
        end else begin
            checks++;
            if (wq[0] !== 9'h011 || wq[2] !== 9'h011 || err_n != 0) begin
                errors++;
                $display("FAIL b2b_bytes: %h %h errs=%0d required 011 011 0", wq[0], wq[2], err_n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_log();
        issue(3'd0, 14'd7, 8'hF4);
        while (wq.size() < 2 && n < 100) begin
            step(1);
            n++;
        end
        checks++;
        if (wq.size() < 2) begin
            errors++;
            $display("FAIL mid_reach: writes=%0d required 2", wq.size());
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (vdp_csw_n !== 1'b1 || vdp_csr_n !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: csw=%b csr=%b ready=%b required 1 1 1", vdp_csw_n, vdp_csr_n, cmd_ready);
        end
        checks++;
        if (vram_addr !== 14'h0) begin
            errors++;
            $display("FAIL mid_vram: %h required 0000", vram_addr);
        end
        step(20);
        checks++;
        if (rsp_n != 0 || err_n != 0 || wq.size() != 2) begin
            errors++;
            $display("FAIL mid_quiet: rsp=%0d errs=%0d writes=%0d required 0 0 2", rsp_n, err_n, wq.size());
        end
        issue(3'd3, 14'h0000, 8'h3C);
        wait_idle();
        checks++;
        if (wq.size() != 3 || wq[wq.size()-1] !== 9'h03C || wlen[wlen.size()-1] != 4) begin
            errors++;
            $display("FAIL mid_resume: writes=%0d required 3 ending 03c", wq.size());
        end
    endtask

    task automatic test_addr_track();
`ifdef VDP_SEQ_ADDR_TRACK_EN
        logic [13:0] exp_tab [4];
        exp_tab[0] = 14'h3FFE;
        exp_tab[1] = 14'h3FFF;
        exp_tab[2] = 14'h0000;
        exp_tab[3] = 14'h0001;
        issue(3'd1, 14'h3FFE, 8'h00);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                issue(3'd3, 14'h0000, 8'(i));
                wait_idle();
            end
            checks++;
            if (vram_addr !== exp_tab[i]) begin
                errors++;
                $display("FAIL track_%0d: vram=%h required %h", i, vram_addr, exp_tab[i]);
            end
        end
        issue(3'd0, 14'd1, 8'h00);
        wait_idle();
        checks++;
        if (vram_addr !== 14'h0001) begin
            errors++;
            $display("FAIL track_reg: vram=%h required 0001", vram_addr);
        end
`else
        issue(3'd1, 14'h3FFE, 8'h00);
        issue(3'd3, 14'h0000, 8'h01);
        wait_idle();
        checks++;
        if (vram_addr !== 14'h0) begin
            errors++;
            $display("FAIL track_off: vram=%h required 0000", vram_addr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_addr_write();
        test_reads();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_addr_track();
        checks++;
        if (both_low != 0) begin
            errors++;
            $display("FAIL strobe_overlap: %0d cycles required 0", both_low);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
